matmul_load_ctrl: RTL and testbench
===================================

MATMUL_LOAD_CTRL -- requirements
Module: matmul_load_ctrl

Interface
REQ-001 SHALL have parameter B_LOADS, default 3: number of load_B_done pulses that complete the B load.
REQ-002 SHALL have parameter CALC_TIMEOUT, default 64: maximum CALC cycles before error; 8-bit range.
REQ-003 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  constant 1.
- load_A_en, load_B_en  out  1 each  buffer load enables.
- valid_input  out  1  data-word strobe to the buffers.
- load_A_done, load_B_done  in  1 each  buffer completion pulses.
- calc_start  out  1  one-cycle compute start.
- calc_done  in  1  compute completion pulse.
- irq  out  1  interrupt.

Function
REQ-004 SHALL define an access as PSEL&PENABLE; addresses: 0x00 CTRL (W: bit0 start, bit1 clear), 0x04 DATA (W), 0x08 STATUS (R); other addresses ignored.
REQ-005 SHALL implement FSM IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, DONE=4, ERR=5; state is registered, and transitions take effect the cycle after the triggering event.
REQ-006 IDLE: CTRL write with bit0=1 -> LOAD_A.
REQ-007 LOAD_A: load_A_en=1; load_A_done=1 -> LOAD_B.
REQ-008 LOAD_B: load_B_en=1; an internal counter counts load_B_done pulses; the pulse that brings the count to B_LOADS -> CALC, and the counter is cleared.
REQ-009 valid_input SHALL be combinational = DATA write access & state in {LOAD_A, LOAD_B}; it is 0 in all other states.
REQ-010 A DATA write in any other state SHALL be dropped and set sticky flag ign; ign is cleared by clear or start.
REQ-011 calc_start SHALL be high exactly during the first cycle of CALC.
REQ-012 CALC: a cycle counter increments from 0 each cycle. calc_done -> DONE with the count frozen. Count reaching CALC_TIMEOUT-1 without calc_done -> ERR. calc_done in the same cycle as the timeout -> DONE.
REQ-013 DONE: start -> LOAD_A (cycle count cleared); clear -> IDLE.
REQ-014 ERR: only clear exits, -> IDLE; start SHALL be ignored.
REQ-015 A clear write SHALL force IDLE from any state, zeroing all counters and flags; with bit0 and bit1 both set, clear wins.
REQ-016 A start write in LOAD_A/LOAD_B/CALC SHALL be ignored.
REQ-017 load_A_done/load_B_done outside their own load state SHALL be ignored.
REQ-018 PRDATA SHALL be combinational STATUS on a read access to 0x08, else 0. STATUS fields: [2:0] state, [3] busy (state 1-3), [4] done, [5] err, [6] ign, [7] irq_pend, [15:8] cycle count, others 0.

Reset
REQ-019 rst=0 at a rising clk edge SHALL force IDLE, all counters 0, ign=0, irq_pend=0, irq=0; this holds from any state, including mid-load and mid-CALC.
REQ-020 During and after reset, load_A_en, load_B_en, valid_input, calc_start and PRDATA SHALL be 0, and PREADY SHALL be 1.

Configuration
REQ-021 Macro MATMUL_CTRL_IRQ_EN defined: irq is registered and pulses 1 cycle on entry to DONE or ERR; irq_pend is set at the same time and cleared by start or clear.
REQ-022 Macro not defined: irq is tied 0, STATUS[7] reads 0, and no irq logic is generated.

Verification
REQ-023 Reset, then read 0x08 -> PRDATA=0; all outputs 0 except PREADY=1.
REQ-024 Start; 3 DATA writes, with load_A_done pulsed on the 3rd; 3 load_B_done pulses (one per B write) -> states 1->2->3, calc_start for 1 cycle; calc_done after 10 cycles -> STATUS=0x0A14 (state 4, done).
REQ-025 CALC with no calc_done -> ERR after 64 cycles, STATUS[5]=1. A start write is then ignored; a clear write -> STATUS=0.
REQ-026 DATA write while in IDLE -> valid_input stays 0, STATUS[6]=1; a subsequent start clears it.
REQ-027 Reset asserted mid-LOAD_B after 1 load_B_done -> IDLE. Restart needs a full 3 load_B_done (the counter was cleared).
REQ-028 With MATMUL_CTRL_IRQ_EN: irq is a single-cycle pulse on entry to DONE, and STATUS[7]=1 until start. Without the macro: irq stays 0 throughout.

Source files
------------

// File: rtl/matmul_load_ctrl.sv
// APB-programmed sequencer: loads the A then B buffers, starts a compute phase, times it out.
// Defining MATMUL_CTRL_IRQ_EN adds the registered irq pulse and the irq_pend status bit.
module matmul_load_ctrl #(
    parameter int B_LOADS      = 3,
    parameter int CALC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        load_A_en,
    output logic        load_B_en,
    output logic        valid_input,
    input  logic        load_A_done,
    input  logic        load_B_done,
    output logic        calc_start,
    input  logic        calc_done,
    output logic        irq
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int            BW     = $clog2(B_LOADS + 1);
    localparam logic [BW-1:0] B_LAST = BW'(B_LOADS - 1);
    localparam logic [7:0]    T_LAST = 8'(CALC_TIMEOUT - 1);

    state_t        state_q;
    logic [BW-1:0] bcnt_q;
    logic [7:0]    cyc_q;
    logic          ign_q;
    logic          calc_start_q;
    logic          irq_pend;

    logic acc, ctrl_wr, data_wr, stat_rd, start, clr, in_load, busy;
    logic [31:0] status;
    logic unused_pwdata;

    assign acc     = PSEL & PENABLE;
    assign ctrl_wr = acc & PWRITE & (PADDR == 8'h00);
    assign data_wr = acc & PWRITE & (PADDR == 8'h04);
    assign stat_rd = acc & ~PWRITE & (PADDR == 8'h08);
    assign start   = ctrl_wr & PWDATA[0];
    assign clr     = ctrl_wr & PWDATA[1];
    assign unused_pwdata = ^PWDATA[31:2];

    assign in_load = (state_q == LOAD_A) | (state_q == LOAD_B);
    assign busy    = in_load | (state_q == CALC);

`ifdef MATMUL_CTRL_IRQ_EN
    logic irq_q, irq_pend_q;
    assign irq      = irq_q;
    assign irq_pend = irq_pend_q;
`else
    assign irq      = 1'b0;
    assign irq_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            cyc_q        <= '0;
            ign_q        <= 1'b0;
            calc_start_q <= 1'b0;
`ifdef MATMUL_CTRL_IRQ_EN
            irq_q        <= 1'b0;
            irq_pend_q   <= 1'b0;
`endif
        end else begin
            calc_start_q <= 1'b0;
`ifdef MATMUL_CTRL_IRQ_EN
            irq_q        <= 1'b0;
`endif
            if (data_wr && !in_load) ign_q <= 1'b1;
            if (clr) begin
                state_q <= IDLE;
                bcnt_q  <= '0;
                cyc_q   <= '0;
                ign_q   <= 1'b0;
`ifdef MATMUL_CTRL_IRQ_EN
                irq_pend_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE, DONE: if (start) begin
                        state_q <= LOAD_A;
                        cyc_q   <= '0;
                        ign_q   <= 1'b0;
`ifdef MATMUL_CTRL_IRQ_EN
                        irq_pend_q <= 1'b0;
`endif
                    end
                    LOAD_A: if (load_A_done) state_q <= LOAD_B;
                    LOAD_B: if (load_B_done) begin
                        if (bcnt_q == B_LAST) begin
                            state_q      <= CALC;
                            bcnt_q       <= '0;
                            cyc_q        <= '0;
                            calc_start_q <= 1'b1;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                    // calc_done outranks the timeout; the count freezes on exit either way
                    CALC: if (calc_done || cyc_q == T_LAST) begin
                        state_q <= calc_done ? DONE : ERR;
`ifdef MATMUL_CTRL_IRQ_EN
                        irq_q      <= 1'b1;
                        irq_pend_q <= 1'b1;
`endif
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                    ERR: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign status = {16'd0, cyc_q, irq_pend, ign_q, state_q == ERR, state_q == DONE, busy, state_q};

    // combinational outputs are held low while reset is asserted
    assign PREADY      = 1'b1;
    assign PRDATA      = (rst && stat_rd) ? status : 32'd0;
    assign load_A_en   = rst & (state_q == LOAD_A);
    assign load_B_en   = rst & (state_q == LOAD_B);
    assign valid_input = rst & data_wr & in_load;
    assign calc_start  = rst & calc_start_q;
endmodule

// File: tb/tb_matmul_load_ctrl.sv
// Bench for matmul_load_ctrl: vector table, directed corner sequences, then random traffic
// checked every cycle against an event-level reference model.
module tb_matmul_load_ctrl;
    localparam int B_LOADS = 3;
    localparam int TMO     = 64;
`ifdef MATMUL_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [31:0] PEND = IRQ_EN ? 32'h80 : 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h0;
    logic [31:0] PWDATA = 32'h0;
    logic        load_A_done = 1'b0, load_B_done = 1'b0, calc_done = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, load_A_en, load_B_en, valid_input, calc_start, irq;

    matmul_load_ctrl #(.B_LOADS(B_LOADS), .CALC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .load_A_en(load_A_en), .load_B_en(load_B_en), .valid_input(valid_input),
        .load_A_done(load_A_done), .load_B_done(load_B_done), .calc_start(calc_start),
        .calc_done(calc_done), .irq(irq)
    );

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // reference model: 0 idle, 1 load A, 2 load B, 3 calc, 4 done, 5 err
    int m_state = 0, m_bcnt = 0, m_cyc = 0;
    bit m_ign = 0, m_pend = 0, m_irq = 0, m_cs = 0, m_valid = 0;

    function automatic logic [31:0] m_status();
        logic busy;
        busy = (m_state >= 1) && (m_state <= 3);
        return {16'd0, 8'(m_cyc), m_pend, m_ign, m_state == 5, m_state == 4, busy, 3'(m_state)};
    endfunction

    task automatic model_step();
        bit access, wr_ctrl, wr_data, go;
        access  = PSEL && PENABLE;
        wr_ctrl = access && PWRITE && PADDR == 8'h00;
        wr_data = access && PWRITE && PADDR == 8'h04;
        go      = wr_ctrl && PWDATA[0];
        m_cs = 0;
        m_irq = 0;
        if (!rst || (wr_ctrl && PWDATA[1])) begin
            m_state = 0; m_bcnt = 0; m_cyc = 0; m_ign = 0; m_pend = 0;
            if (!rst) m_valid = 1;
            return;
        end
        if (wr_data && m_state != 1 && m_state != 2) m_ign = 1;
        if (m_state == 0 || m_state == 4) begin
            if (go) begin m_state = 1; m_cyc = 0; m_ign = 0; m_pend = 0; end
        end else if (m_state == 1) begin
            if (load_A_done) m_state = 2;
        end else if (m_state == 2) begin
            if (load_B_done) begin
                m_bcnt++;
                if (m_bcnt == B_LOADS) begin m_bcnt = 0; m_state = 3; m_cyc = 0; m_cs = 1; end
            end
        end else if (m_state == 3) begin
            if (calc_done || m_cyc == TMO - 1) begin
                m_state = calc_done ? 4 : 5;
                m_irq = IRQ_EN;
                m_pend = IRQ_EN;
            end else begin
                m_cyc++;
            end
        end
    endtask

    task automatic model_check();
        bit access, rd, wd;
        access = PSEL && PENABLE;
        rd = access && !PWRITE && PADDR == 8'h08;
        wd = access && PWRITE && PADDR == 8'h04;
        chk("bg_prdata", PRDATA, (rst && rd) ? m_status() : 32'd0);
        chk("bg_load_a", 32'(load_A_en), 32'(rst && m_state == 1));
        chk("bg_load_b", 32'(load_B_en), 32'(rst && m_state == 2));
        chk("bg_valid", 32'(valid_input), 32'(rst && wd && (m_state == 1 || m_state == 2)));
        chk("bg_cstart", 32'(calc_start), 32'(rst && m_cs));
        chk("bg_irq", 32'(irq), 32'(m_irq));
        chk("bg_pready", 32'(PREADY), 32'd1);
    endtask

    // snapshot order: {load_A_en, load_B_en, valid_input, calc_start, irq, PREADY}
    logic [31:0] s_prd;
    logic [5:0]  s_ctl;

    task automatic tick(input logic r, input logic ps, input logic pe, input logic pw,
                        input logic [7:0] pa, input logic [31:0] wd,
                        input logic ad, input logic bd, input logic cd);
        rst = r; PSEL = ps; PENABLE = pe; PWRITE = pw; PADDR = pa; PWDATA = wd;
        load_A_done = ad; load_B_done = bd; calc_done = cd;
        @(negedge clk);
        s_prd = PRDATA;
        s_ctl = {load_A_en, load_B_en, valid_input, calc_start, irq, PREADY};
        if (m_valid) model_check();
        @(posedge clk);
        model_step();
        #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0; load_A_done = 0; load_B_done = 0; calc_done = 0;
    endtask

    task automatic idle();                                    tick(1, 0, 0, 0, 8'h0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d); tick(1, 1, 1, 1, a, d, 0, 0, 0); endtask
    task automatic rd(input logic [7:0] a);                   tick(1, 1, 1, 0, a, 0, 0, 0, 0); endtask
    task automatic pulse(input logic ad, input logic bd, input logic cd); tick(1, 0, 0, 0, 8'h0, 0, ad, bd, cd); endtask

    typedef struct {
        string       nm;
        logic        ps, pe, pw;
        logic [7:0]  pa;
        logic [31:0] wd;
        logic        ad, bd, cd;
        logic [5:0]  ctl;
        logic [31:0] prd;
    } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{"rd_idle",    1, 1, 0, 8'h08, 32'h0,  0, 0, 0, 6'b000001, 32'h0};
        tbl[1]  = '{"start",      1, 1, 1, 8'h00, 32'h1,  0, 0, 0, 6'b000001, 32'h0};
        tbl[2]  = '{"data_a0",    1, 1, 1, 8'h04, 32'h11, 0, 0, 0, 6'b101001, 32'h0};
        tbl[3]  = '{"setup_only", 1, 0, 1, 8'h04, 32'h12, 0, 0, 0, 6'b100001, 32'h0};
        tbl[4]  = '{"data_a1",    1, 1, 1, 8'h04, 32'h13, 0, 0, 0, 6'b101001, 32'h0};
        tbl[5]  = '{"data_a2",    1, 1, 1, 8'h04, 32'h14, 1, 0, 0, 6'b101001, 32'h0};
        tbl[6]  = '{"rd_load_b",  1, 1, 0, 8'h08, 32'h0,  0, 0, 0, 6'b010001, 32'h0A};
        tbl[7]  = '{"data_b0",    1, 1, 1, 8'h04, 32'h21, 0, 1, 0, 6'b011001, 32'h0};
        tbl[8]  = '{"data_b1",    1, 1, 1, 8'h04, 32'h22, 0, 1, 0, 6'b011001, 32'h0};
        tbl[9]  = '{"data_b2",    1, 1, 1, 8'h04, 32'h23, 0, 1, 0, 6'b011001, 32'h0};
        tbl[10] = '{"calc_first", 0, 0, 0, 8'h00, 32'h0,  0, 0, 0, 6'b000101, 32'h0};
        tbl[11] = '{"rd_calc",    1, 1, 0, 8'h08, 32'h0,  0, 0, 0, 6'b000001, 32'h010B};
        tbl[12] = '{"start_calc", 1, 1, 1, 8'h00, 32'h1,  0, 0, 0, 6'b000001, 32'h0};
        tbl[13] = '{"rd_calc2",   1, 1, 0, 8'h08, 32'h0,  0, 0, 0, 6'b000001, 32'h030B};
        tbl[14] = '{"rd_bad_adr", 1, 1, 0, 8'h0C, 32'h0,  0, 0, 0, 6'b000001, 32'h0};

        @(posedge clk);
        model_step();
        #1;
        tick(0, 1, 1, 0, 8'h08, 0, 0, 0, 0);
        chk("rst_held_prd", s_prd, 32'h0);
        chk("rst_held_ctl", 32'(s_ctl), 32'h01);
        rd(8'h08);
        chk("rst_rd_prd", s_prd, 32'h0);
        chk("rst_rd_ctl", 32'(s_ctl), 32'h01);

        foreach (tbl[i]) begin
            tick(1, tbl[i].ps, tbl[i].pe, tbl[i].pw, tbl[i].pa, tbl[i].wd, tbl[i].ad, tbl[i].bd, tbl[i].cd);
            chk({tbl[i].nm, "_ctl"}, 32'(s_ctl), 32'(tbl[i].ctl));
            chk({tbl[i].nm, "_prd"}, s_prd, tbl[i].prd);
        end

        // compute finishes with the count at 10
        repeat (5) idle();
        pulse(0, 0, 1);
        rd(8'h08);
        chk("done_status", s_prd, 32'h0A14 | PEND);
        chk("done_irq", 32'(s_ctl[1]), 32'(IRQ_EN));
        idle();
        chk("done_irq_drop", 32'(s_ctl[1]), 32'h0);
        rd(8'h08);
        chk("done_status2", s_prd, 32'h0A14 | PEND);

        // restart from DONE, then run into the timeout
        wr(8'h00, 32'h1);
        rd(8'h08);
        chk("restart_status", s_prd, 32'h09);
        tick(1, 1, 1, 1, 8'h04, 32'h5, 1, 0, 0);
        repeat (3) pulse(0, 1, 0);
        repeat (63) idle();
        rd(8'h08);
        chk("calc_last", s_prd, 32'h3F0B);
        rd(8'h08);
        chk("err_status", s_prd, 32'h3F25 | PEND);
        chk("err_irq", 32'(s_ctl[1]), 32'(IRQ_EN));
        wr(8'h00, 32'h1);
        rd(8'h08);
        chk("err_start_ign", s_prd, 32'h3F25 | PEND);
        wr(8'h00, 32'h2);
        rd(8'h08);
        chk("err_clear", s_prd, 32'h0);

        // dropped DATA write in IDLE
        wr(8'h04, 32'hDEAD);
        chk("ign_valid", 32'(s_ctl[3]), 32'h0);
        rd(8'h08);
        chk("ign_set", s_prd, 32'h40);
        wr(8'h00, 32'h1);
        rd(8'h08);
        chk("ign_cleared", s_prd, 32'h09);

        // reset in the middle of LOAD_B; B count must restart from zero
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        tick(0, 0, 0, 0, 8'h0, 0, 0, 0, 0);
        rd(8'h08);
        chk("midb_rst", s_prd, 32'h0);
        wr(8'h00, 32'h1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        rd(8'h08);
        chk("midb_two", s_prd, 32'h0A);
        pulse(0, 1, 0);
        rd(8'h08);
        chk("midb_calc", s_prd, 32'h0B);
        chk("midb_cstart", 32'(s_ctl[2]), 32'h1);
        wr(8'h00, 32'h3);
        rd(8'h08);
        chk("clear_wins", s_prd, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  pa;
            logic [31:0] wd;
            case ($urandom_range(0, 7))
                0, 1:    pa = 8'h00;
                2, 3, 4: pa = 8'h04;
                5, 6:    pa = 8'h08;
                default: pa = 8'($urandom);
            endcase
            wd = $urandom;
            wd[1] = ($urandom_range(0, 15) == 0);
            tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), pa, wd, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
